mouse_cursor_tracker: RTL
=========================

# mouse_cursor_tracker

Parametrised cursor engine for the PS/2 mouse path. Consumes decoded movement packets from the PS/2 mouse decoder and keeps a clamped, speed-scaled on-screen cursor. Derives grid-block coordinates with an in-grid flag, single-cycle click pulses, and a timed right-click-burst cheat trigger. Feeds the game FSM and VGA cursor overlay.

## Interface
- `SCREEN_W`, 640: horizontal pixels; x range 0..SCREEN_W-1
- `SCREEN_H`, 480: vertical pixels; y range 0..SCREEN_H-1
- `X_W`, 10: width of `mouse_x`
- `Y_W`, 9: width of `mouse_y`
- `SPEED_SHIFT`, 0: movement gain; delta is left-shifted by this amount
- `GRID_X0`, 32: pixel x of the grid's left edge
- `GRID_Y0`, 176: pixel y of the grid's top edge
- `BLOCK_LOG2`, 5: block side is 2^BLOCK_LOG2 pixels
- `GRID_COLS`, 18: number of block columns
- `GRID_ROWS`, 8: number of block rows
- `CHEAT_CLICKS`, 4: right clicks needed to fire the cheat
- `CHEAT_WINDOW`, 50_000_000: cycle budget for a click burst
- `clk` in 1: system clock
- `rst` in 1: synchronous, active-low reset
- `pkt_valid` in 1: one-cycle strobe; packet fields below are valid
- `dx` in 9: two's-complement X delta (sign bit + 8 bits)
- `x_ov` in 1: X overflow flag
- `dy` in 9: two's-complement Y delta; positive means up
- `y_ov` in 1: Y overflow flag
- `l_btn` in 1: left button level
- `r_btn` in 1: right button level
- `mouse_x` out X_W: cursor x
- `mouse_y` out Y_W: cursor y
- `mouse_block_x` out 5: column index
- `mouse_block_y` out 3: row index
- `mouse_inblock` out 1: cursor lies inside the grid
- `l_click` out 1: one-cycle pulse on a left-button press
- `r_click` out 1: one-cycle pulse on a right-button press
- `cheat_activate` out 1: one-cycle pulse when a burst completes

## Operation
- **Delta**
  - If `x_ov` is set, the effective dx saturates to +255 or -256 according to the sign of `dx`.
  - The effective delta is sign-extended to X_W+SPEED_SHIFT+2 bits, then shifted left by SPEED_SHIFT.
  - Y follows the same rule, but the result is subtracted because screen y grows downward.
- **Position**
  - new = pos + delta, then clamped to [0, SCREEN_W-1] (or [0, SCREEN_H-1] for y).
  - The position never wraps.
  - The position updates only on `pkt_valid`.
- **Block mapping** (combinational from the registered position)
  - bx = (x-GRID_X0) >> BLOCK_LOG2; by = (y-GRID_Y0) >> BLOCK_LOG2.
  - `mouse_inblock` = x ≥ GRID_X0 && y ≥ GRID_Y0 && bx < GRID_COLS && by < GRID_ROWS.
  - When `mouse_inblock` is 0, the block outputs are 0.
- **Clicks**
  - `prev_l` and `prev_r` latch the button levels on each `pkt_valid`.
  - A click is `pkt_valid` && btn && !prev.
  - Simultaneous left and right presses produce both pulses.
- **Burst FSM** (states IDLE, COUNT)
  - IDLE: an `r_click` moves to COUNT with cnt=1 and timer=0.
  - COUNT: the timer increments every cycle; each `r_click` increments cnt.
  - An `l_click` or timer = CHEAT_WINDOW-1 returns to IDLE with cnt=0.
  - When cnt would reach CHEAT_CLICKS, `cheat_activate` pulses and the FSM returns to IDLE.
  - If an `l_click` and an `r_click` arrive in the same cycle, the `l_click` wins: reset, no increment.

## Timing
- **Reset values:** `mouse_x`=SCREEN_W/2 (320), `mouse_y`=SCREEN_H/2 (240). All pulses, `prev_*`, cnt and timer are 0; the FSM is in IDLE.
- **Position:** the registered position, and therefore the block outputs, reflect a packet on the first clock edge after its `pkt_valid`.
- **Click pulses:** registered, high for exactly one cycle following the packet edge.
- **`cheat_activate`:** asserts in the same cycle as the completing `r_click`.
- **`pkt_valid` on consecutive cycles:** each packet is applied in turn; no packet is dropped.
- **Reset asserted mid-burst:** the FSM returns to IDLE and the cursor is recentred on that edge.

## Configuration
- `MOUSE_CHEAT_EN` defined: the burst FSM and timer are built as specified above.
- Undefined:
  - `cheat_activate` is tied to 0 and no timer or counter flops exist.
  - Clicks and position are unchanged.

## Structure
- **Package `mouse_pkg`:**
  - Default screen and grid constants.
  - Burst FSM state enum.
  - Saturation constants ±255/-256.
- **Sub-module `click_burst_detector`:** contains the FSM and timer, with inputs `l_click` and `r_click` and output `cheat_activate`. It is instantiated only under `MOUSE_CHEAT_EN`.

## Test plan
- Reset, then one packet with dx=+10, dy=+5 -> `mouse_x`=330, `mouse_y`=235; `mouse_block_x`=9, `mouse_block_y`=1, `mouse_inblock`=1.
- From reset, dx=-256 with `x_ov`, repeated 3 times -> `mouse_x` clamps at 0; `mouse_inblock`=0 and the block outputs are 0.
- With SPEED_SHIFT=1: dx=+200 repeated -> x increments by 400, then clamps at 639; dy=-255 repeated -> y clamps at 479.
- Packets with `l_btn` sequence 0,1,1,0,1 -> exactly two `l_click` pulses, each 1 cycle wide.
- Four right presses, each released between presses, inside the window -> one `cheat_activate` pulse on the 4th press. Three presses, then an `l_click`, then one press -> no pulse.
- Three right presses, then an idle gap of CHEAT_WINDOW cycles, then one press -> no pulse. With `MOUSE_CHEAT_EN` undefined, `cheat_activate` stays 0 throughout.

Source files
------------

// File: rtl/mouse_pkg.sv
// Shared constants, burst FSM state encoding and delta saturation helper for the
// PS/2 cursor engine.
package mouse_pkg;

  localparam int DEF_SCREEN_W     = 640;
  localparam int DEF_SCREEN_H     = 480;
  localparam int DEF_GRID_X0      = 32;
  localparam int DEF_GRID_Y0      = 176;
  localparam int DEF_BLOCK_LOG2   = 5;
  localparam int DEF_GRID_COLS    = 18;
  localparam int DEF_GRID_ROWS    = 8;
  localparam int DEF_CHEAT_CLICKS = 4;
  localparam int DEF_CHEAT_WINDOW = 50_000_000;

  localparam logic signed [8:0] DELTA_SAT_POS = 9'sb0_1111_1111;
  localparam logic signed [8:0] DELTA_SAT_NEG = 9'sb1_0000_0000;

  typedef enum logic {
    BURST_IDLE,
    BURST_COUNT
  } burst_state_e;

  // An overflowed PS/2 delta saturates toward the sign it reported.
  function automatic logic signed [8:0] sat_delta(input logic [8:0] d, input logic ov);
    if (ov) return d[8] ? DELTA_SAT_NEG : DELTA_SAT_POS;
    return $signed(d);
  endfunction

endpackage

// File: rtl/click_burst_detector.sv
// Counts right clicks inside a cycle window; pulses cheat_activate (registered, one
// edge after the completing click event) and rearms. A left click aborts the burst.
module click_burst_detector
  import mouse_pkg::*;
#(
  parameter int CHEAT_CLICKS = DEF_CHEAT_CLICKS,
  parameter int CHEAT_WINDOW = DEF_CHEAT_WINDOW
) (
  input  logic clk,
  input  logic rst,
  input  logic l_click,
  input  logic r_click,
  output logic cheat_activate
);
  localparam int CNT_W = (CHEAT_CLICKS < 2) ? 1 : $clog2(CHEAT_CLICKS + 1);
  localparam int TMR_W = (CHEAT_WINDOW < 2) ? 1 : $clog2(CHEAT_WINDOW);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CHEAT_WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHEAT_CLICKS - 1);

  burst_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [TMR_W-1:0] timer_q;
  logic             cheat_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= BURST_IDLE;
      cnt_q   <= '0;
      timer_q <= '0;
      cheat_q <= 1'b0;
    end else begin
      cheat_q <= 1'b0;
      case (state_q)
        BURST_IDLE: begin
          if (r_click && !l_click) begin
            timer_q <= '0;
            if (CHEAT_CLICKS <= 1) begin
              cheat_q <= 1'b1;
            end else begin
              state_q <= BURST_COUNT;
              cnt_q   <= CNT_W'(1);
            end
          end
        end
        BURST_COUNT: begin
          timer_q <= timer_q + 1'b1;
          // Abort and window expiry both outrank a coincident right click.
          if (l_click || timer_q == TMR_LAST) begin
            state_q <= BURST_IDLE;
            cnt_q   <= '0;
            timer_q <= '0;
          end else if (r_click) begin
            if (cnt_q == CNT_LAST) begin
              cheat_q <= 1'b1;
              state_q <= BURST_IDLE;
              cnt_q   <= '0;
              timer_q <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= BURST_IDLE;
      endcase
    end
  end

  assign cheat_activate = cheat_q;

endmodule

// File: rtl/mouse_cursor_tracker.sv
// Clamped, speed-scaled cursor with grid mapping and click pulses; position and pulses
// update one edge after pkt_valid. Right-click burst cheat built only with MOUSE_CHEAT_EN.
module mouse_cursor_tracker
  import mouse_pkg::*;
#(
  parameter int SCREEN_W     = DEF_SCREEN_W,
  parameter int SCREEN_H     = DEF_SCREEN_H,
  parameter int X_W          = 10,
  parameter int Y_W          = 9,
  parameter int SPEED_SHIFT  = 0,
  parameter int GRID_X0      = DEF_GRID_X0,
  parameter int GRID_Y0      = DEF_GRID_Y0,
  parameter int BLOCK_LOG2   = DEF_BLOCK_LOG2,
  parameter int GRID_COLS    = DEF_GRID_COLS,
  parameter int GRID_ROWS    = DEF_GRID_ROWS,
  parameter int CHEAT_CLICKS = DEF_CHEAT_CLICKS,
  parameter int CHEAT_WINDOW = DEF_CHEAT_WINDOW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pkt_valid,
  input  logic [8:0]     dx,
  input  logic           x_ov,
  input  logic [8:0]     dy,
  input  logic           y_ov,
  input  logic           l_btn,
  input  logic           r_btn,
  output logic [X_W-1:0] mouse_x,
  output logic [Y_W-1:0] mouse_y,
  output logic [4:0]     mouse_block_x,
  output logic [2:0]     mouse_block_y,
  output logic           mouse_inblock,
  output logic           l_click,
  output logic           r_click,
  output logic           cheat_activate
);
  localparam int XS_W = X_W + SPEED_SHIFT + 2;
  localparam int YS_W = Y_W + SPEED_SHIFT + 2;
  localparam logic signed [XS_W-1:0] X_MAX = XS_W'(SCREEN_W - 1);
  localparam logic signed [YS_W-1:0] Y_MAX = YS_W'(SCREEN_H - 1);

  logic [X_W-1:0]         x_q, x_d;
  logic [Y_W-1:0]         y_q, y_d;
  logic                   prev_l_q, prev_r_q;
  logic                   l_click_q, r_click_q;
  logic                   l_click_d, r_click_d;
  logic signed [8:0]      dx_eff, dy_eff;
  logic signed [XS_W-1:0] x_step, x_sum;
  logic signed [YS_W-1:0] y_step, y_sum;

  always_comb begin
    dx_eff = sat_delta(dx, x_ov);
    dy_eff = sat_delta(dy, y_ov);
    x_step = XS_W'(dx_eff) <<< SPEED_SHIFT;
    y_step = YS_W'(dy_eff) <<< SPEED_SHIFT;
    x_sum  = $signed(XS_W'(x_q)) + x_step;
    // Screen y grows downward while the mouse reports up as positive.
    y_sum  = $signed(YS_W'(y_q)) - y_step;
    x_d    = x_q;
    y_d    = y_q;
    if (pkt_valid) begin
      if (x_sum[XS_W-1])     x_d = '0;
      else if (x_sum > X_MAX) x_d = X_W'(SCREEN_W - 1);
      else                   x_d = x_sum[X_W-1:0];
      if (y_sum[YS_W-1])     y_d = '0;
      else if (y_sum > Y_MAX) y_d = Y_W'(SCREEN_H - 1);
      else                   y_d = y_sum[Y_W-1:0];
    end
  end

  assign l_click_d = pkt_valid && l_btn && !prev_l_q;
  assign r_click_d = pkt_valid && r_btn && !prev_r_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      x_q       <= X_W'(SCREEN_W / 2);
      y_q       <= Y_W'(SCREEN_H / 2);
      prev_l_q  <= 1'b0;
      prev_r_q  <= 1'b0;
      l_click_q <= 1'b0;
      r_click_q <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      l_click_q <= l_click_d;
      r_click_q <= r_click_d;
      if (pkt_valid) begin
        prev_l_q <= l_btn;
        prev_r_q <= r_btn;
      end
    end
  end

  logic [X_W-1:0] x_off, bx_full;
  logic [Y_W-1:0] y_off, by_full;
  logic           in_grid;

  always_comb begin
    x_off   = x_q - X_W'(GRID_X0);
    y_off   = y_q - Y_W'(GRID_Y0);
    bx_full = x_off >> BLOCK_LOG2;
    by_full = y_off >> BLOCK_LOG2;
    in_grid = (x_q >= X_W'(GRID_X0)) && (y_q >= Y_W'(GRID_Y0)) &&
              (bx_full < X_W'(GRID_COLS)) && (by_full < Y_W'(GRID_ROWS));
  end

  assign mouse_x       = x_q;
  assign mouse_y       = y_q;
  assign mouse_inblock = in_grid;
  assign mouse_block_x = in_grid ? bx_full[4:0] : 5'd0;
  assign mouse_block_y = in_grid ? by_full[2:0] : 3'd0;
  assign l_click       = l_click_q;
  assign r_click       = r_click_q;

`ifdef MOUSE_CHEAT_EN
  // Fed with the pre-register click events so its registered pulse lines up with r_click.
  click_burst_detector #(
    .CHEAT_CLICKS(CHEAT_CLICKS),
    .CHEAT_WINDOW(CHEAT_WINDOW)
  ) u_burst (
    .clk           (clk),
    .rst           (rst),
    .l_click       (l_click_d),
    .r_click       (r_click_d),
    .cheat_activate(cheat_activate)
  );
`else
  assign cheat_activate = 1'b0;
`endif

endmodule
